interl_addr_ctrl: RTL and testbench

INTERL_ADDR_CTRL -- requirements
Module: interl_addr_ctrl

---
 rtl/interl_pkg.sv | 15 +
 rtl/interl_rc_cnt.sv | 50 +++++
 rtl/interl_addr_ctrl.sv | 106 ++++++++++
 tb/tb_interl_addr_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/interl_pkg.sv
// Shared sizing for the block interleaver: matrix shape, RAM address width and
// the derived bank/park addresses used by the controller and the wrapper.
package interl_pkg;
    localparam int ADDR_WIDTH = 14;
    localparam int ROWS       = 64;
    localparam int COLS       = 120;
    localparam int N          = ROWS * COLS;
    localparam int BANK       = 2 ** (ADDR_WIDTH - 1);
    localparam int PARK       = 2 ** ADDR_WIDTH - 1;

    // Counter width for a 0..range-1 counter, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction
endpackage

// File: rtl/interl_rc_cnt.sv
// Two-level wrap counter: inner runs 0..INNER-1, outer advances on inner wrap.
// last_o flags the final (INNER-1, OUTER-1) position so callers can swap banks.
module interl_rc_cnt
    import interl_pkg::*;
#(
    parameter int INNER = 3,
    parameter int OUTER = 4
) (
    input  logic                    clk,
    input  logic                    clr_i,
    input  logic                    step_i,
    output logic [cnt_w(INNER)-1:0] inner_o,
    output logic [cnt_w(OUTER)-1:0] outer_o,
    output logic                    last_o
);
    localparam int IW = cnt_w(INNER);
    localparam int OW = cnt_w(OUTER);

    logic [IW-1:0] inner_q, inner_d;
    logic [OW-1:0] outer_q, outer_d;
    logic          inner_wrap;

    assign inner_wrap = (inner_q == IW'(INNER - 1));
    assign last_o     = inner_wrap && (outer_q == OW'(OUTER - 1));
    assign inner_o    = inner_q;
    assign outer_o    = outer_q;

    always_comb begin
        inner_d = inner_q;
        outer_d = outer_q;
        if (step_i) begin
            if (inner_wrap) begin
                inner_d = '0;
                outer_d = last_o ? '0 : outer_q + 1'b1;
            end else begin
                inner_d = inner_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            inner_q <= '0;
            outer_q <= '0;
        end else begin
            inner_q <= inner_d;
            outer_q <= outer_d;
        end
    end
endmodule

// File: rtl/interl_addr_ctrl.sv
// Address and flow control for a ping-pong ROWS x COLS block interleaver:
// one RAM bank is filled row-wise while the other is drained column-wise.
module interl_addr_ctrl #(
    parameter int ADDR_WIDTH = interl_pkg::ADDR_WIDTH,
    parameter int ROWS       = interl_pkg::ROWS,
    parameter int COLS       = interl_pkg::COLS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] wr_ram_counter,
    output logic                  in_bit_data,
    output logic [ADDR_WIDTH-1:0] r_ram_counter,
    input  logic                  read_data_out,
    output logic                  m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);
    import interl_pkg::cnt_w;

    localparam int BANK = 2 ** (ADDR_WIDTH - 1);
    localparam int PARK = 2 ** ADDR_WIDTH - 1;
    localparam logic [ADDR_WIDTH-1:0] BANK_A = ADDR_WIDTH'(BANK);
    localparam logic [ADDR_WIDTH-1:0] PARK_A = ADDR_WIDTH'(PARK);
    localparam logic [ADDR_WIDTH-1:0] COLS_A = ADDR_WIDTH'(COLS);

    logic [cnt_w(ROWS)-1:0] row, r;
    logic [cnt_w(COLS)-1:0] col, c;
    logic                   wr_hs, wr_last, rd_adv, rd_last;
    logic [1:0]             full_q, full_d;
    logic                   wb_q, wb_d, rb_q, rb_d;
    logic                   m_data_q, m_data_d, m_valid_q, m_valid_d, m_last_q, m_last_d;

    // s_ready comes from registered flags only, so s_valid never loops back to it.
    assign s_ready = !full_q[wb_q];
    assign wr_hs   = s_valid && s_ready && !rst;
    assign rd_adv  = full_q[rb_q] && (!m_valid_q || m_ready);

    // The RAM writes on every edge, so idle cycles are steered to the park address.
    assign wr_ram_counter = wr_hs ? (wb_q ? BANK_A : '0) + ADDR_WIDTH'(row) * COLS_A + ADDR_WIDTH'(col)
                                  : PARK_A;
    assign r_ram_counter  = (rb_q ? BANK_A : '0) + ADDR_WIDTH'(r) * COLS_A + ADDR_WIDTH'(c);
    assign in_bit_data    = s_data;
    assign m_data         = m_data_q;
    assign m_valid        = m_valid_q;
    assign m_last         = m_last_q;

    interl_rc_cnt #(.INNER(COLS), .OUTER(ROWS)) u_wr_cnt (
        .clk(clk), .clr_i(rst), .step_i(wr_hs),
        .inner_o(col), .outer_o(row), .last_o(wr_last)
    );

    interl_rc_cnt #(.INNER(ROWS), .OUTER(COLS)) u_rd_cnt (
        .clk(clk), .clr_i(rst), .step_i(rd_adv),
        .inner_o(r), .outer_o(c), .last_o(rd_last)
    );

    // Write needs !full[wb] and read needs full[rb], so both updates never hit one bank.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        if (wr_hs && wr_last) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        if (rd_adv && rd_last) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end
    end

    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        if (rd_adv) begin
            m_data_d  = read_data_out;
            m_valid_d = 1'b1;
            m_last_d  = rd_last;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wb_q      <= 1'b0;
            rb_q      <= 1'b0;
            m_data_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            full_q    <= full_d;
            wb_q      <= wb_d;
            rb_q      <= rb_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end
endmodule

// File: tb/tb_interl_addr_ctrl.sv
// Directed bench for interl_addr_ctrl on a 4x3 matrix with a 32-entry RAM model.
module tb_interl_addr_ctrl;
    localparam int AW = 5;
    localparam int R  = 4;
    localparam int C  = 3;

    logic          clk = 1'b0, rst = 1'b1;
    logic          s_data = 1'b0, s_valid = 1'b0, s_ready;
    logic [AW-1:0] wr_ram_counter, r_ram_counter;
    logic          in_bit_data, read_data_out;
    logic          m_data, m_valid, m_last, m_ready = 1'b1;

    logic mem [0:31];

    int passed = 0, total = 0, failed = 0;
    int wcount = 0, addr_err = 0, idle_err = 0, stall_cnt = 0, hold_err = 0;
    int phase = 0;
    bit stall_mode = 1'b0;
    logic [3:0] rdy_pat = 4'b1001;
    logic oq[$];
    logic lq[$];
    logic prev_stall = 1'b0, prev_data = 1'b0, prev_last = 1'b0;

    interl_addr_ctrl #(.ADDR_WIDTH(AW), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .wr_ram_counter(wr_ram_counter), .in_bit_data(in_bit_data),
        .r_ram_counter(r_ram_counter), .read_data_out(read_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem[wr_ram_counter] <= in_bit_data;
    assign read_data_out = mem[r_ram_counter];

    // Output capture plus hold check for cycles that follow a stalled beat.
    always @(posedge clk) begin
        if (!rst && prev_stall && (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last))
            hold_err++;
        if (!rst && m_valid && m_ready) begin
            oq.push_back(m_data);
            lq.push_back(m_last);
        end
        prev_stall <= !rst && m_valid && !m_ready;
        prev_data  <= m_data;
        prev_last  <= m_last;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] perm(input logic [11:0] b);
        logic [11:0] o;
        for (int k = 0; k < 12; k++) o[k] = b[(k % R) * C + k / R];
        return o;
    endfunction

    function automatic logic [AW-1:0] exp_addr(input int w);
        return AW'(((w / 12) % 2) * 16 + (w % 12));
    endfunction

    task automatic tick();
        @(negedge clk);
        if (stall_mode) begin
            m_ready = rdy_pat[phase % 4];
            phase++;
        end
        #1;
    endtask

    task automatic send(input logic [47:0] bits, input int n, input bit gappy,
                        input int maxc, output int hs);
        hs = 0;
        for (int cyc = 0; cyc < maxc && hs < n; cyc++) begin
            tick();
            s_valid = gappy ? 1'($urandom_range(1)) : 1'b1;
            s_data  = bits[hs];
            #1;
            if (s_valid && s_ready) begin
                if (wr_ram_counter !== exp_addr(wcount)) addr_err++;
                if (in_bit_data !== s_data) addr_err++;
                wcount++;
                hs++;
            end else begin
                if (wr_ram_counter !== 5'd31) idle_err++;
                if (s_valid) stall_cnt++;
            end
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic get_block(output logic [11:0] d, output logic [11:0] l);
        int cyc = 0;
        d = '0;
        l = '0;
        while (oq.size() < 12 && cyc < 300) begin
            tick();
            cyc++;
        end
        if (oq.size() < 12) chk("out_timeout", oq.size(), 12);
        else for (int k = 0; k < 12; k++) begin
            d[k] = oq.pop_front();
            l[k] = lq.pop_front();
        end
    endtask

    task automatic chk_block(input string tag, input logic [11:0] in_bits);
        logic [11:0] d, l;
        get_block(d, l);
        chk({tag, "_data"}, d, perm(in_bits));
        chk({tag, "_last"}, l, 12'h800);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        oq.delete();
        lq.delete();
        wcount = 0;
        addr_err = 0;
        idle_err = 0;
        stall_cnt = 0;
    endtask

    initial begin
        logic [47:0] stream;
        logic [11:0] d, l;
        int hs;

        // Reset state, with s_valid high to show the write address stays parked.
        s_valid = 1'b1;
        s_data  = 1'b1;
        tick();
        tick();
        chk("rst_park", wr_ram_counter, 5'd31);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_mlast", m_last, 1'b0);
        rst = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("ready_after_rst", s_ready, 1'b1);

        // Basic permutation and latency.
        stream = 48'hA5C;
        send(stream, 12, 1'b0, 100, hs);
        chk("t1_hs", hs, 12);
        chk("t1_lat_k", m_valid, 1'b0);
        chk("t1_ready_k", s_ready, 1'b1);
        tick();
        chk("t1_lat_k1", m_valid, 1'b1);
        chk("t1_first_bit", m_data, 1'b0);
        get_block(d, l);
        chk("t1_data", d, 12'h92E);
        chk("t1_last", l, 12'h800);
        chk("t1_addr", addr_err, 0);

        // Ping-pong streaming, banks 0,1,0.
        do_reset();
        stream = {12'h000, 12'h3C6, 12'hF0F, 12'h1B9};
        send(stream, 36, 1'b0, 100, hs);
        chk("t2_hs", hs, 36);
        chk("t2_no_drop", stall_cnt, 0);
        chk("t2_addr", addr_err, 0);
        chk_block("t2_b0", stream[11:0]);
        chk_block("t2_b1", stream[23:12]);
        chk_block("t2_b2", stream[35:24]);

        // Back-pressure: two full banks then stall.
        m_ready = 1'b0;
        do_reset();
        stream = {12'h000, 12'h0A7, 12'hD52, 12'h6E3};
        send(stream, 30, 1'b0, 40, hs);
        chk("t3_hs", hs, 24);
        chk("t3_ready_low", s_ready, 1'b0);
        chk("t3_stall_cycles", stall_cnt, 16);
        chk("t3_park", idle_err, 0);
        chk("t3_hold_valid", m_valid, 1'b1);
        chk("t3_hold_bit", m_data, stream[0]);
        m_ready = 1'b1;
        send(stream >> 24, 6, 1'b0, 100, hs);
        chk("t3_tail_hs", hs, 6);
        chk("t3_addr", addr_err, 0);
        chk_block("t3_b0", stream[11:0]);
        chk_block("t3_b1", stream[23:12]);
        repeat (20) tick();
        chk("t3_no_extra", oq.size(), 0);

        // Output stall with m_ready pattern 1,0,0,1.
        do_reset();
        stall_mode = 1'b1;
        phase = 0;
        stream = 48'hA5C;
        send(stream, 12, 1'b0, 100, hs);
        chk_block("t4", stream[11:0]);
        stall_mode = 1'b0;
        m_ready = 1'b1;
        chk("t4_hold", hold_err, 0);

        // Gappy input.
        do_reset();
        stream = 48'h5E1;
        send(stream, 12, 1'b1, 400, hs);
        chk("t5_hs", hs, 12);
        chk("t5_idle_park", idle_err, 0);
        chk("t5_addr", addr_err, 0);
        chk_block("t5", stream[11:0]);

        // Reset mid-block discards the partial block.
        do_reset();
        stream = 48'h07F;
        send(stream, 7, 1'b0, 50, hs);
        rst = 1'b1;
        s_valid = 1'b1;
        tick();
        chk("t6_rst_mvalid", m_valid, 1'b0);
        chk("t6_rst_park", wr_ram_counter, 5'd31);
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        oq.delete();
        lq.delete();
        wcount = 0;
        addr_err = 0;
        tick();
        chk("t6_after_mvalid", m_valid, 1'b0);
        chk("t6_after_ready", s_ready, 1'b1);
        stream = 48'hC93;
        send(stream, 12, 1'b0, 100, hs);
        chk("t6_addr", addr_err, 0);
        chk_block("t6", stream[11:0]);
        repeat (20) tick();
        chk("t6_no_extra", oq.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
